// File: rtl/mul_man_seq_normalizer.sv
// mul_man_seq_normalizer: radix-2 sequential mantissa multiplier with normalization and round-to-nearest-even request
module mul_man_seq_normalizer #(
  parameter int SIZE_MAN = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_busy,
  output logic                o_done,
  output logic [SIZE_MAN-1:0] o_man,
  output logic                o_rounding_bit,
  output logic                o_exp_adj
);
  localparam int W  = 2 * SIZE_MAN;
  localparam int CW = $clog2(SIZE_MAN + 1);
  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;
  state_t              r_state;
  logic [W-1:0]        r_mcand;
  logic [W-1:0]        r_acc;
  logic [SIZE_MAN-1:0] r_mplier;
  logic [CW-1:0]       r_cnt;
  logic                w_hi;
  logic                w_guard;
  logic                w_sticky;
  logic                w_lsb;
  logic [SIZE_MAN-1:0] w_man;
  // a set top bit means the product lies in [2,4) and the window slides up by one
  assign w_hi     = r_acc[W-1];
  assign w_man    = w_hi ? r_acc[W-1:SIZE_MAN] : r_acc[W-2:SIZE_MAN-1];
  assign w_guard  = w_hi ? r_acc[SIZE_MAN-1] : r_acc[SIZE_MAN-2];
  assign w_sticky = w_hi ? |r_acc[SIZE_MAN-2:0] : |r_acc[SIZE_MAN-3:0];
  assign w_lsb    = w_hi ? r_acc[SIZE_MAN] : r_acc[SIZE_MAN-1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_mcand        <= '0;
      r_acc          <= '0;
      r_mplier       <= '0;
      r_cnt          <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_man          <= '0;
      o_rounding_bit <= 1'b0;
      o_exp_adj      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_mcand  <= {{SIZE_MAN{1'b0}}, i_man_a};
          r_mplier <= i_man_b;
          r_acc    <= '0;
          r_cnt    <= '0;
          o_busy   <= 1'b1;
          r_state  <= CALC;
        end
        CALC: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(SIZE_MAN - 1)) r_state <= NORM;
        end
        NORM: begin
          o_man          <= w_man;
          o_rounding_bit <= w_guard & (w_sticky | w_lsb);
          o_exp_adj      <= w_hi;
          o_done         <= 1'b1;
          o_busy         <= 1'b0;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mul_man_seq_normalizer.md
MUL_MAN_SEQ_NORMALIZER -- requirements
Module: mul_man_seq_normalizer

Interface
REQ-001 Parameter SIZE_MAN, default 24: mantissa width including hidden bit.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  request to start a multiply; sampled in IDLE only.
REQ-005 i_man_a  input  SIZE_MAN  operand A mantissa, hidden bit included.
REQ-006 i_man_b  input  SIZE_MAN  operand B mantissa, hidden bit included.
REQ-007 o_busy  output  1  high while a multiply is in progress (CALC or NORM).
REQ-008 o_done  output  1  one-cycle pulse when results are valid.
REQ-009 o_man  output  SIZE_MAN  normalized, truncated mantissa; feeds the downstream rounding stage.
REQ-010 o_rounding_bit  output  1  round-to-nearest-even increment request for o_man.
REQ-011 o_exp_adj  output  1  product was in [2,4); the exponent stage adds 1.

Function
REQ-012 FSM states: IDLE, CALC, NORM; encoding is free.
REQ-013 In IDLE with i_start=1, the block SHALL latch i_man_a and i_man_b, clear the 2*SIZE_MAN-bit accumulator and the iteration counter, and go to CALC.
REQ-014 In IDLE with i_start=0, the block SHALL stay in IDLE.
REQ-015 CALC SHALL process exactly one multiplier bit per cycle, LSB first, by radix-2 shift-add, for SIZE_MAN cycles.
REQ-016 After the SIZE_MAN-th iteration, the FSM SHALL go to NORM.
REQ-017 Accumulator width SHALL be 2*SIZE_MAN bits with no overflow loss; the final product P equals i_man_a*i_man_b exactly.
REQ-018 NORM lasts one cycle, registers the outputs and pulses o_done, then returns to IDLE.
REQ-019 Normalization when P[2*SIZE_MAN-1]=1:
- o_man = P[2*SIZE_MAN-1:SIZE_MAN]
- guard = P[SIZE_MAN-1]
- sticky = OR of P[SIZE_MAN-2:0]
- lsb = P[SIZE_MAN]
- o_exp_adj = 1
REQ-020 Normalization otherwise:
- o_man = P[2*SIZE_MAN-2:SIZE_MAN-1]
- guard = P[SIZE_MAN-2]
- sticky = OR of P[SIZE_MAN-3:0]
- lsb = P[SIZE_MAN-1]
- o_exp_adj = 0
REQ-021 o_rounding_bit SHALL equal guard & (sticky | lsb).
REQ-022 Latency: with i_start accepted at rising edge k, o_done SHALL be high for exactly the cycle following edge k+SIZE_MAN+1; o_busy SHALL be high from edge k until edge k+SIZE_MAN+1.
REQ-023 o_man, o_rounding_bit and o_exp_adj SHALL change only at the edge that raises o_done, and hold until the next such edge.
REQ-024 i_start asserted while o_busy=1 SHALL be ignored; operand changes during CALC have no effect.
REQ-025 i_start=1 in the cycle o_done is high SHALL be accepted, because the FSM is already in IDLE (back-to-back throughput of one result every SIZE_MAN+2 cycles).
REQ-026 A zero operand SHALL produce o_man=0, o_rounding_bit=0 and o_exp_adj=0 with unchanged latency.
REQ-027 The block SHALL perform no exponent, sign or special-value handling.

Reset
REQ-028 While i_rst_n=0, the FSM SHALL be in IDLE, the counter and accumulator 0, and o_busy=0, o_done=0, o_man=0, o_rounding_bit=0, o_exp_adj=0, independent of i_clk.
REQ-029 Reset asserted mid-CALC or mid-NORM SHALL abort the operation with no o_done pulse.
REQ-030 After reset release, the first i_start SHALL be accepted on the first rising edge.

Verification
REQ-031 a=0x800000, b=0x800000 -> o_man=0x800000, o_rounding_bit=0, o_exp_adj=0, o_done exactly SIZE_MAN+1 edges after start.
REQ-032 a=0xFFFFFF, b=0xFFFFFF (P=0xFFFFFE000001) -> o_man=0xFFFFFE, o_rounding_bit=0, o_exp_adj=1.
REQ-033 a=0x800001, b=0xC00000 (P=0x600000C00000) -> o_man=0xC00001, o_rounding_bit=1 (tie, odd lsb), o_exp_adj=0.
REQ-034 a=0x800003, b=0xC00000 (P=0x600002400000) -> o_man=0xC00004, o_rounding_bit=0 (tie, even lsb).
REQ-035 i_start pulsed again during CALC with new operands -> ignored, first result unchanged; i_start held high through o_done -> second operation starts and completes SIZE_MAN+2 cycles later.
REQ-036 i_rst_n pulled low at CALC iteration 10 -> all outputs 0 immediately, no o_done pulse; next start after release -> correct result.
